sequential_load_packer: RTL and testbench

//  Load-side counterpart of the store path: consumes AXI R beats and packs the requested nibbles into

---
 rtl/vlsu_pkg.sv | 31 +++
 rtl/seq_load_nb_align.sv | 33 +++
 rtl/sequential_load_packer.sv | 160 ++++++++++++++++
 tb/tb_sequential_load_packer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// Shared constants and types for the vector load/store unit.
// Default geometry, FSM states and AXI response codes.
package vlsu_pkg;

  localparam int NrLanesDef = 4;
  localparam int DlenDef    = 64;
  localparam int AxiDwDef   = 128;
  localparam int TotNbWDef  = 16;

  localparam int SeqNbs = DlenDef / 4 * NrLanesDef;
  localparam int BusNbs = AxiDwDef / 4;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DRAIN
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(
    input logic [1:0] resp
  );
    return (resp == RESP_SLVERR) ||
           (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/seq_load_nb_align.sv
// Beat nibble aligner: drops leading nibbles, keeps len,
// and places them at the accumulator insert position.
module seq_load_nb_align #(
  parameter int BusNb    = 32,
  parameter int AccNb    = 96,
  parameter int BusNSize = 5,
  parameter int InNbW    = 6,
  parameter int PosW     = 7
) (
  input  logic [BusNb*4-1:0]    data_i,
  input  logic [BusNSize-1:0]   base_i,
  input  logic [InNbW-1:0]      len_i,
  input  logic [PosW-1:0]       pos_i,
  output logic [AccNb*4-1:0]    data_o
);

  logic [BusNb*4-1:0] shifted;
  logic [BusNb*4-1:0] masked;
  logic [AccNb*4-1:0] wide;

  always_comb begin
    shifted = data_i >> {base_i, 2'b00};
    masked  = '0;
    for (int i = 0; i < BusNb; i++) begin
      if (i < int'(len_i)) begin
        masked[i*4 +: 4] = shifted[i*4 +: 4];
      end
    end
    wide   = (AccNb*4)'(masked);
    data_o = wide << {pos_i, 2'b00};
  end

endmodule

// File: rtl/sequential_load_packer.sv
// Packs AXI R beats into lane-wide sequence words,
// trimming the start offset and flagging the last word.
module sequential_load_packer
  import vlsu_pkg::*;
#(
  parameter int NrLanes      = NrLanesDef,
  parameter int DLEN         = DlenDef,
  parameter int AxiDataWidth = AxiDwDef,
  parameter int TotNbW       = TotNbWDef,
  localparam int SeqNb    = DLEN / 4 * NrLanes,
  localparam int BusNb    = AxiDataWidth / 4,
  localparam int BusNSize = $clog2(BusNb),
  localparam int OutNbW   = $clog2(SeqNb + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    txn_valid_i,
  output logic                    txn_ready_o,
  input  logic [BusNSize-1:0]     txn_start_nb_i,
  input  logic [TotNbW-1:0]       txn_total_nb_i,
  input  logic                    axi_r_valid_i,
  output logic                    axi_r_ready_o,
  input  logic [AxiDataWidth-1:0] axi_r_data_i,
  input  logic [1:0]              axi_r_resp_i,
  input  logic                    axi_r_last_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [SeqNb*4-1:0]      out_data_o,
  output logic [OutNbW-1:0]       out_nbs_o,
  output logic                    out_last_o,
  output logic                    err_o,
  input  logic                    err_clr_i
);

  localparam int AccNb = SeqNb + BusNb;
  localparam int FillW = $clog2(AccNb + 1);
  localparam int InNbW = $clog2(BusNb + 1);

  state_e              state_q, state_d;
  logic [FillW-1:0]    fill_q, fill_d, pos;
  logic [TotNbW-1:0]   rem_q, rem_d, rem_nxt;
  logic                first_q, first_d;
  logic [BusNSize-1:0] off_q, off_d, base;
  logic [AccNb*4-1:0]  acc_q, acc_d, ins;
  logic                err_q, err_d, err_set;
  logic [InNbW-1:0]    avail, in_nb;
  logic [OutNbW-1:0]   out_nb;
  logic                out_hs, r_hs, full;

  always_comb begin
    full   = fill_q >= FillW'(SeqNb);
    out_nb = full ? OutNbW'(SeqNb)
                  : OutNbW'(fill_q);

    out_valid_o = (state_q == RECV && full) ||
                  (state_q == DRAIN && fill_q != '0);
    out_last_o  = (state_q == DRAIN) &&
                  (fill_q <= FillW'(SeqNb));
    out_nbs_o   = out_nb;
    out_data_o  = acc_q[SeqNb*4-1:0];
    out_hs      = out_valid_o && out_ready_i;

    txn_ready_o   = state_q == IDLE;
    // Draining a full word frees space for the next beat
    axi_r_ready_o = (state_q == RECV) &&
                    (!full || out_hs);
    r_hs          = axi_r_ready_o && axi_r_valid_i;

    base  = first_q ? off_q : '0;
    avail = InNbW'(BusNb) - InNbW'(base);
    in_nb = (TotNbW'(avail) <= rem_q) ? avail
                                      : InNbW'(rem_q);
    pos   = out_hs ? fill_q - FillW'(out_nb)
                   : fill_q;
    rem_nxt = rem_q - TotNbW'(in_nb);
  end

  seq_load_nb_align #(
    .BusNb   (BusNb),
    .AccNb   (AccNb),
    .BusNSize(BusNSize),
    .InNbW   (InNbW),
    .PosW    (FillW)
  ) u_align (
    .data_i(axi_r_data_i),
    .base_i(base),
    .len_i (in_nb),
    .pos_i (pos),
    .data_o(ins)
  );

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    first_d = first_q;
    off_d   = off_q;
    acc_d   = acc_q;
    err_d   = err_q;

    err_set = r_hs &&
              (resp_is_err(axi_r_resp_i) ||
               (axi_r_last_i != (rem_nxt == '0)));

    if (out_hs) begin
      acc_d  = acc_q >> {out_nb, 2'b00};
      fill_d = pos;
    end
    if (r_hs) begin
      acc_d   = acc_d | ins;
      fill_d  = pos + FillW'(in_nb);
      rem_d   = rem_nxt;
      first_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (txn_valid_i) begin
          state_d = RECV;
          off_d   = txn_start_nb_i;
          rem_d   = txn_total_nb_i;
          first_d = 1'b1;
        end
      end
      RECV: begin
        if (r_hs && rem_nxt == '0) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_hs && out_last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_set) err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
  end

  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      fill_q  <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      off_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      off_q   <= off_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sequential_load_packer.sv
// Directed bench for sequential_load_packer.
// Words are captured by a monitor and checked against hand values.
module tb_sequential_load_packer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         txn_valid, txn_ready;
  logic [4:0]   start_nb;
  logic [15:0]  total_nb;
  logic         r_valid, r_ready;
  logic [127:0] r_data;
  logic [1:0]   r_resp;
  logic         r_last;
  logic         out_valid, out_ready;
  logic [255:0] out_data;
  logic [6:0]   out_nbs;
  logic         out_last;
  logic         err, err_clr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [255:0] wq_data[$];
  logic [6:0]   wq_nbs[$];
  logic         wq_last[$];
  int           last_hs_cyc[$];
  int           txn_hs_cyc[$];

  logic [127:0] a, b, c, d, e;
  logic [127:0] p [5];

  always #5 clk = ~clk;

  sequential_load_packer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .txn_valid_i   (txn_valid),
    .txn_ready_o   (txn_ready),
    .txn_start_nb_i(start_nb),
    .txn_total_nb_i(total_nb),
    .axi_r_valid_i (r_valid),
    .axi_r_ready_o (r_ready),
    .axi_r_data_i  (r_data),
    .axi_r_resp_i  (r_resp),
    .axi_r_last_i  (r_last),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_data_o    (out_data),
    .out_nbs_o     (out_nbs),
    .out_last_o    (out_last),
    .err_o         (err),
    .err_clr_i     (err_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        wq_data.push_back(out_data);
        wq_nbs.push_back(out_nbs);
        wq_last.push_back(out_last);
        if (out_last) last_hs_cyc.push_back(cyc);
      end
      if (txn_valid && txn_ready) txn_hs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [4:0] s,
                           input logic [15:0] t);
    int n = 0;
    txn_valid = 1'b1;
    start_nb  = s;
    total_nb  = t;
    @(negedge clk);
    while (!txn_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("txn_accept", 256'(txn_ready), 256'(1));
    tick();
    txn_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] dat,
                           input logic [1:0] resp,
                           input logic last);
    int n = 0;
    r_valid = 1'b1;
    r_data  = dat;
    r_resp  = resp;
    r_last  = last;
    @(negedge clk);
    while (!r_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat_accept", 256'(r_ready), 256'(1));
    tick();
    r_valid = 1'b0;
    r_resp  = 2'b00;
    r_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!txn_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idle", 256'(txn_ready), 256'(1));
    tick();
  endtask

  task automatic expect_word(input string tag,
                             input logic [255:0] dat,
                             input logic [6:0] nbs,
                             input logic last);
    chk({tag, "_avail"},
        256'(wq_data.size() != 0), 256'(1));
    if (wq_data.size() != 0) begin
      chk({tag, "_data"}, wq_data.pop_front(), dat);
      chk({tag, "_nbs"},
          256'(wq_nbs.pop_front()), 256'(nbs));
      chk({tag, "_last"},
          256'(wq_last.pop_front()), 256'(last));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a = 128'h0123456789abcdeffedcba9876543210;
    b = 128'h13579bdf2468ace00f1e2d3c4b5a6978;
    c = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
    d = 128'hd0d1d2d3d4d5d6d7d8d9dadbdcdddedf;
    e = 128'he0e1e2e3e4e5e6e7e8e9eaebecedeeef;
    for (int i = 0; i < 5; i++)
      p[i] = {4{32'h5a5a0000 | 32'(i * 17 + 3)}};

    rst_n     = 1'b0;
    txn_valid = 1'b0;
    start_nb  = '0;
    total_nb  = '0;
    r_valid   = 1'b0;
    r_data    = '0;
    r_resp    = 2'b00;
    r_last    = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("rst_txn_ready", 256'(txn_ready), 256'(1));
    chk("rst_r_ready", 256'(r_ready), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_last", 256'(out_last), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_nbs", 256'(out_nbs), 256'(0));

    // Two full beats form one word
    start_txn(5'd0, 16'd64);
    send_beat(a, 2'b00, 1'b0);
    send_beat(b, 2'b00, 1'b1);
    wait_idle();
    expect_word("t1", {b, a}, 7'd64, 1'b1);
    chk("t1_err", 256'(err), 256'(0));

    // Offset first beat, short last beat
    start_txn(5'd8, 16'd60);
    send_beat(c, 2'b00, 1'b0);
    send_beat(d, 2'b00, 1'b0);
    send_beat(e, 2'b00, 1'b1);
    wait_idle();
    expect_word("t2", {16'h0, e[15:0], d, c[127:32]},
                7'd60, 1'b1);
    chk("t2_err", 256'(err), 256'(0));

    // Backpressure on the output stalls R
    out_ready = 1'b0;
    start_txn(5'd0, 16'd160);
    send_beat(p[0], 2'b00, 1'b0);
    send_beat(p[1], 2'b00, 1'b0);
    r_valid = 1'b1;
    r_data  = p[2];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_rready_low", 256'(r_ready), 256'(0));
      chk("t3_out_valid", 256'(out_valid), 256'(1));
    end
    chk("t3_no_word", 256'(wq_data.size()), 256'(0));
    tick();
    out_ready = 1'b1;
    send_beat(p[2], 2'b00, 1'b0);
    send_beat(p[3], 2'b00, 1'b0);
    send_beat(p[4], 2'b00, 1'b1);
    wait_idle();
    expect_word("t3w0", {p[1], p[0]}, 7'd64, 1'b0);
    expect_word("t3w1", {p[3], p[2]}, 7'd64, 1'b0);
    expect_word("t3w2", {128'h0, p[4]}, 7'd32, 1'b1);
    chk("t3_err", 256'(err), 256'(0));

    // Error response is sticky until cleared
    start_txn(5'd0, 16'd64);
    send_beat(a, 2'b00, 1'b0);
    send_beat(b, 2'b10, 1'b1);
    wait_idle();
    expect_word("t4a", {b, a}, 7'd64, 1'b1);
    chk("t4_err_set", 256'(err), 256'(1));
    repeat (2) tick();
    chk("t4_err_hold", 256'(err), 256'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", 256'(err), 256'(0));

    // Early rlast sets err even with clear asserted
    start_txn(5'd0, 16'd64);
    err_clr = 1'b1;
    send_beat(a, 2'b00, 1'b1);
    err_clr = 1'b0;
    chk("t4_rlast_err", 256'(err), 256'(1));
    send_beat(b, 2'b00, 1'b1);
    wait_idle();
    expect_word("t4b", {b, a}, 7'd64, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4b_err_clr", 256'(err), 256'(0));

    // Reset mid-transaction discards data
    start_txn(5'd0, 16'd160);
    send_beat(p[0], 2'b00, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_txn_ready", 256'(txn_ready), 256'(1));
    chk("t5_out_valid", 256'(out_valid), 256'(0));
    chk("t5_nbs", 256'(out_nbs), 256'(0));
    chk("t5_r_ready", 256'(r_ready), 256'(0));
    repeat (5) tick();
    chk("t5_no_word", 256'(wq_data.size()), 256'(0));
    chk("t5_out_valid2", 256'(out_valid), 256'(0));

    // Back-to-back descriptors with valid held
    txn_hs_cyc.delete();
    last_hs_cyc.delete();
    start_nb  = 5'd0;
    total_nb  = 16'd32;
    txn_valid = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!txn_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t6_first_accept", 256'(txn_ready), 256'(1));
      tick();
      send_beat(a, 2'b00, 1'b1);
      n = 0;
      while (txn_hs_cyc.size() < 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    tick();
    txn_valid = 1'b0;
    chk("t6_txn_count", 256'(txn_hs_cyc.size()), 256'(2));
    if (txn_hs_cyc.size() >= 2 && last_hs_cyc.size() >= 1)
      chk("t6_gap",
          256'(txn_hs_cyc[1] - last_hs_cyc[0]), 256'(1));
    expect_word("t6a", {128'h0, a}, 7'd32, 1'b1);
    send_beat(b, 2'b00, 1'b1);
    wait_idle();
    expect_word("t6b", {128'h0, b}, 7'd32, 1'b1);
    chk("t6_err", 256'(err), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
